// File: rtl/alu_arb_pkg.sv
// Shared types and defaults for the two-requester ALU share arbiter.
package alu_arb_pkg;

  localparam int DATA_W_DEF = 4;
  localparam int MODE_W_DEF = 3;
  localparam int CNT_W      = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_e;

endpackage

// File: rtl/alu_rr_arbiter.sv
// Two-way round-robin arbiter: a tie goes to the requester not granted last,
// a lone request is granted regardless of history.
module alu_rr_arbiter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_i,
  input  logic       accept_i,
  output logic [1:0] grant_o
);

  logic last_q;

  // Winner selection from current requests and the last-grant pointer.
  always_comb begin
    grant_o = 2'b00;
    if (req_i == 2'b11) begin
      grant_o = last_q ? 2'b01 : 2'b10;
    end else begin
      grant_o = req_i;
    end
  end

  // Pointer starts at 1 so requester 0 wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= 1'b1;
    end else if (accept_i) begin
      last_q <= grant_o[1];
    end else begin
      last_q <= last_q;
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one combinational 4-bit ALU between two requesters, one op in flight.
// Optional sticky per-requester overflow flags: define ALU_ARB_OVF_STICKY_EN.
module alu_share_arbiter
  import alu_arb_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int MODE_W     = MODE_W_DEF,
  parameter int SETTLE_CYC = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            req_valid,
  output logic [1:0]            req_ready,
  input  logic [2*DATA_W-1:0]   req_a,
  input  logic [2*DATA_W-1:0]   req_b,
  input  logic [1:0]            req_c,
  input  logic [2*MODE_W-1:0]   req_mode,
  output logic [DATA_W-1:0]     alu_a,
  output logic [DATA_W-1:0]     alu_b,
  output logic                  alu_c,
  output logic [MODE_W-1:0]     alu_mode,
  input  logic [DATA_W-1:0]     alu_r,
  input  logic                  alu_ovf,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_id,
  output logic [DATA_W-1:0]     rsp_r,
  output logic                  rsp_ovf,
  output logic [1:0]            ovf_sticky,
  input  logic [1:0]            sticky_clr
);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       grant_s;
  logic             accept_s;
  logic             gid_s;

  alu_rr_arbiter u_rr (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_i    (req_valid),
    .accept_i (accept_s),
    .grant_o  (grant_s)
  );

  assign req_ready = (state_q == IDLE) ? grant_s : 2'b00;
  assign accept_s  = |(req_ready & req_valid);
  assign gid_s     = grant_s[1];

  // Operation FSM with registered ALU drive and response capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= {CNT_W{1'b0}};
      alu_a     <= {DATA_W{1'b0}};
      alu_b     <= {DATA_W{1'b0}};
      alu_c     <= 1'b0;
      alu_mode  <= {MODE_W{1'b0}};
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_r     <= {DATA_W{1'b0}};
      rsp_ovf   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept_s) begin
            alu_a    <= gid_s ? req_a[2*DATA_W-1:DATA_W]    : req_a[DATA_W-1:0];
            alu_b    <= gid_s ? req_b[2*DATA_W-1:DATA_W]    : req_b[DATA_W-1:0];
            alu_c    <= gid_s ? req_c[1]                    : req_c[0];
            alu_mode <= gid_s ? req_mode[2*MODE_W-1:MODE_W] : req_mode[MODE_W-1:0];
            rsp_id   <= gid_s;
            cnt_q    <= CNT_W'(SETTLE_CYC - 1);
            state_q  <= ISSUE;
          end
        end
        ISSUE: begin
          // Operands have been stable for SETTLE_CYC cycles once cnt reaches zero.
          if (cnt_q == {CNT_W{1'b0}}) begin
            rsp_r     <= alu_r;
            rsp_ovf   <= alu_ovf;
            rsp_valid <= 1'b1;
            state_q   <= RESP;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1'b1);
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state_q   <= IDLE;
          end
        end
        default: begin
          rsp_valid <= 1'b0;
          state_q   <= IDLE;
        end
      endcase
    end
  end

`ifdef ALU_ARB_OVF_STICKY_EN
  logic [1:0] sticky_q;
  logic [1:0] sticky_d;
  logic [1:0] set_s;

  // A set on the handshake overrides a clear of the same bit.
  always_comb begin
    set_s = 2'b00;
    if (rsp_valid && rsp_ready && rsp_ovf) begin
      set_s = rsp_id ? 2'b10 : 2'b01;
    end else begin
      set_s = 2'b00;
    end
    sticky_d = (sticky_q & ~sticky_clr) | set_s;
  end

  // Sticky flag storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_q <= 2'b00;
    end else begin
      sticky_q <= sticky_d;
    end
  end

  assign ovf_sticky = sticky_q;
`else
  logic [1:0] unused_clr_s;
  assign unused_clr_s = sticky_clr;
  assign ovf_sticky   = 2'b00;
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter with an XOR ALU stub (R = A ^ B, overFlow = C).
module tb_alu_share_arbiter;

  localparam int SETTLE = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] req_valid = 2'b00, req_ready;
  logic [7:0] req_a = 8'h00, req_b = 8'h00;
  logic [1:0] req_c = 2'b00;
  logic [5:0] req_mode = 6'h00;
  logic [3:0] alu_a, alu_b, alu_r, rsp_r;
  logic       alu_c, alu_ovf, rsp_valid, rsp_id, rsp_ovf;
  logic [2:0] alu_mode;
  logic       rsp_ready = 1'b0;
  logic [1:0] ovf_sticky, sticky_clr = 2'b00;

  logic [1:0] req_valid3 = 2'b00, req_ready3;
  logic [7:0] req_a3 = 8'h00, req_b3 = 8'h00;
  logic [1:0] req_c3 = 2'b00;
  logic [5:0] req_mode3 = 6'h00;
  logic [3:0] alu_a3, alu_b3, alu_r3, rsp_r3;
  logic       alu_c3, alu_ovf3, rsp_valid3, rsp_id3, rsp_ovf3;
  logic [2:0] alu_mode3;
  logic       rsp_ready3 = 1'b0;
  logic [1:0] ovf_sticky3;
  logic [1:0] sticky_clr3 = 2'b00;

  assign alu_r    = alu_a ^ alu_b;
  assign alu_ovf  = alu_c;
  assign alu_r3   = alu_a3 ^ alu_b3;
  assign alu_ovf3 = alu_c3;

  alu_share_arbiter #(.DATA_W(4), .MODE_W(3), .SETTLE_CYC(SETTLE)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_c(req_c), .req_mode(req_mode),
    .alu_a(alu_a), .alu_b(alu_b), .alu_c(alu_c), .alu_mode(alu_mode),
    .alu_r(alu_r), .alu_ovf(alu_ovf), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_r(rsp_r), .rsp_ovf(rsp_ovf),
    .ovf_sticky(ovf_sticky), .sticky_clr(sticky_clr)
  );

  alu_share_arbiter #(.DATA_W(4), .MODE_W(3), .SETTLE_CYC(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid3), .req_ready(req_ready3),
    .req_a(req_a3), .req_b(req_b3), .req_c(req_c3), .req_mode(req_mode3),
    .alu_a(alu_a3), .alu_b(alu_b3), .alu_c(alu_c3), .alu_mode(alu_mode3),
    .alu_r(alu_r3), .alu_ovf(alu_ovf3), .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3),
    .rsp_id(rsp_id3), .rsp_r(rsp_r3), .rsp_ovf(rsp_ovf3),
    .ovf_sticky(ovf_sticky3), .sticky_clr(sticky_clr3)
  );

  int n_checks = 0;
  int n_fail = 0;

  // Reference model: an in-flight op record, the last-granted requester and sticky flags.
  int         cyc = 0;
  int         acc_cyc = 0;
  bit         busy = 1'b0;
  bit         have_op = 1'b0;
  bit         last_id = 1'b1;
  bit         exp_valid_now = 1'b0;
  logic       op_id = 1'b0;
  logic [3:0] op_a = 4'h0, op_b = 4'h0;
  logic       op_c = 1'b0;
  logic [2:0] op_mode = 3'h0;
  logic [1:0] st_model = 2'b00;
  bit         dut_ids[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic timeout(input string tag);
    n_checks++;
    n_fail++;
    $error("FAIL %s: wait bound expired", tag);
  endtask

  task automatic model_reset();
    busy = 1'b0; have_op = 1'b0; last_id = 1'b1; st_model = 2'b00; exp_valid_now = 1'b0;
  endtask

  // One clock cycle of the main DUT: check at negedge+1, then advance the model at posedge.
  task automatic step();
    logic [1:0] er, setb;
    bit ev, hs;
    int k;
    #1;
    if (busy)                    er = 2'b00;
    else if (req_valid == 2'b11) er = last_id ? 2'b01 : 2'b10;
    else                         er = req_valid;
    chk("req_ready", req_ready, er);
    ev = busy && ((cyc - acc_cyc) >= SETTLE + 1);
    exp_valid_now = ev;
    chk("rsp_valid", rsp_valid, ev);
    if (ev) begin
      chk("rsp_id", rsp_id, op_id);
      chk("rsp_r", rsp_r, op_a ^ op_b);
      chk("rsp_ovf", rsp_ovf, op_c);
    end
    if (have_op) begin
      chk("alu_a", alu_a, op_a);
      chk("alu_b", alu_b, op_b);
      chk("alu_c", alu_c, op_c);
      chk("alu_mode", alu_mode, op_mode);
    end else begin
      chk("alu_a_idle", {alu_a, alu_b, alu_c, alu_mode}, 12'h000);
    end
`ifdef ALU_ARB_OVF_STICKY_EN
    chk("ovf_sticky", ovf_sticky, st_model);
`else
    chk("ovf_sticky_off", ovf_sticky, 2'b00);
`endif
    hs = ev && rsp_ready;
    if (hs) dut_ids.push_back(rsp_id);
    k = cyc;
    @(posedge clk);
    cyc++;
    setb = (hs && op_c) ? (op_id ? 2'b10 : 2'b01) : 2'b00;
    st_model = (st_model & ~sticky_clr) | setb;
    if (hs) busy = 1'b0;
    if (er != 2'b00) begin
      busy = 1'b1; have_op = 1'b1; acc_cyc = k;
      op_id = er[1]; last_id = er[1];
      op_a    = er[1] ? req_a[7:4]    : req_a[3:0];
      op_b    = er[1] ? req_b[7:4]    : req_b[3:0];
      op_c    = er[1] ? req_c[1]      : req_c[0];
      op_mode = er[1] ? req_mode[5:3] : req_mode[2:0];
    end
    @(negedge clk);
  endtask

  // Asserts reset at a negedge, checks outputs clear without a clock edge, releases.
  task automatic apply_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_alu", {alu_a, alu_b, alu_c, alu_mode}, 12'h000);
    chk("rst_rsp", {rsp_valid, rsp_id, rsp_r, rsp_ovf}, 7'h00);
    chk("rst_sticky", ovf_sticky, 2'b00);
    model_reset();
    repeat (2) begin
      @(negedge clk);
      #1 chk("rst_rsp_valid", rsp_valid, 1'b0);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic drain();
    int t;
    req_valid = 2'b00;
    rsp_ready = 1'b1;
    sticky_clr = 2'b00;
    t = 0;
    while (busy && t < 20) begin step(); t++; end
    if (busy) timeout("drain");
    step();
    rsp_ready = 1'b0;
  endtask

  task automatic run_op(input bit id, input logic [3:0] a, input logic [3:0] b,
                        input logic c, input logic [1:0] clr_hs);
    int t;
    if (id) begin req_a[7:4] = a; req_b[7:4] = b; req_c[1] = c; req_valid = 2'b10; end
    else    begin req_a[3:0] = a; req_b[3:0] = b; req_c[0] = c; req_valid = 2'b01; end
    rsp_ready = 1'b0;
    t = 0;
    while (!busy && t < 20) begin step(); t++; end
    if (!busy) timeout("run_op_accept");
    req_valid = 2'b00;
    t = 0;
    while (!exp_valid_now && t < 20) begin step(); t++; end
    if (!exp_valid_now) timeout("run_op_rsp");
    rsp_ready = 1'b1;
    sticky_clr = clr_hs;
    step();
    rsp_ready = 1'b0;
    sticky_clr = 2'b00;
  endtask

  initial begin
    int g0, t;
    @(negedge clk);
    apply_reset();

    // Test 1: single op from requester 0, response two cycles after accept.
    req_a = 8'h05; req_b = 8'h0A; req_c = 2'b01; req_mode = 6'h00;
    req_valid = 2'b01; rsp_ready = 1'b0;
    step();
    req_valid = 2'b00;
    step();
    step();
    chk("t1_valid", rsp_valid, 1'b1);
    chk("t1_id", rsp_id, 1'b0);
    chk("t1_r", rsp_r, 4'b1111);
    chk("t1_ovf", rsp_ovf, 1'b1);
    drain();

    // Test 2: permanent tie after reset alternates 0,1,0,1 at full throughput.
    apply_reset();
    g0 = dut_ids.size();
    req_a = 8'h3C; req_b = 8'h96; req_c = 2'b10; req_mode = 6'h2B;
    req_valid = 2'b11; rsp_ready = 1'b1;
    repeat (16) step();
    chk("tie_count", dut_ids.size() - g0, 5);
    for (int i = 0; i < 4; i++) chk("tie_order", dut_ids[g0 + i], i % 2);
    drain();

    // Test 3: backpressure holds the response and blocks both requesters.
    req_a = 8'h70; req_b = 8'h20; req_c = 2'b10; req_mode = 6'h38;
    req_valid = 2'b10; rsp_ready = 1'b0;
    step();
    req_valid = 2'b11;
    t = 0;
    while (!exp_valid_now && t < 20) begin step(); t++; end
    if (!exp_valid_now) timeout("bp_rsp");
    repeat (5) step();
    chk("bp_r", rsp_r, 4'h5);
    rsp_ready = 1'b1;
    req_valid = 2'b00;
    step();
    rsp_ready = 1'b0;
    step();
    drain();

    // Test 4: SETTLE_CYC=3 instance, operands stable cycles 1-3, response at cycle 4.
    req_a3 = 8'h0C; req_b3 = 8'h05; req_c3 = 2'b00; req_mode3 = 6'h05;
    req_valid3 = 2'b01;
    #1 chk("t4_ready", req_ready3, 2'b01);
    @(negedge clk);
    req_valid3 = 2'b00;
    for (int i = 1; i <= 3; i++) begin
      #1;
      chk("t4_alu", {alu_a3, alu_b3, alu_c3, alu_mode3}, {4'hC, 4'h5, 1'b0, 3'h5});
      chk("t4_early_valid", rsp_valid3, 1'b0);
      @(negedge clk);
    end
    #1;
    chk("t4_valid", rsp_valid3, 1'b1);
    chk("t4_r", rsp_r3, 4'h9);
    rsp_ready3 = 1'b1;
    @(negedge clk);
    rsp_ready3 = 1'b0;
    #1;
    chk("t4_done", rsp_valid3, 1'b0);
    chk("t4_hold", alu_a3, 4'hC);
    @(negedge clk);

    // Test 5: reset during ISSUE drops the op; the next tie goes to requester 0.
    req_a = 8'h11; req_b = 8'h22; req_c = 2'b11; req_mode = 6'h09;
    req_valid = 2'b01; rsp_ready = 1'b1;
    step();
    req_valid = 2'b00;
    apply_reset();
    req_valid = 2'b11;
    step();
    req_valid = 2'b00;
    drain();

    // Test 6: sticky overflow set, set-beats-clear, then clear alone.
    run_op(1'b1, 4'h3, 4'h4, 1'b1, 2'b00);
    step();
`ifdef ALU_ARB_OVF_STICKY_EN
    chk("sticky_set", ovf_sticky, 2'b10);
`else
    chk("sticky_off", ovf_sticky, 2'b00);
`endif
    run_op(1'b1, 4'h6, 4'h1, 1'b1, 2'b10);
    step();
`ifdef ALU_ARB_OVF_STICKY_EN
    chk("sticky_set_wins", ovf_sticky, 2'b10);
`else
    chk("sticky_off", ovf_sticky, 2'b00);
`endif
    sticky_clr = 2'b10;
    step();
    sticky_clr = 2'b00;
    step();
    chk("sticky_clr", ovf_sticky, 2'b00);

    // Randomised traffic with dropping requests, backpressure and clears.
    for (int i = 0; i < 400; i++) begin
      req_valid  = 2'($urandom);
      req_a      = 8'($urandom);
      req_b      = 8'($urandom);
      req_c      = 2'($urandom);
      req_mode   = 6'($urandom);
      rsp_ready  = ($urandom_range(0, 3) != 0);
      sticky_clr = ($urandom_range(0, 7) == 0) ? 2'($urandom) : 2'b00;
      step();
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
